// File: rtl/pipe_arbiter.sv
// Round-robin front end that shares one fixed-latency 4-operand pipe between two
// requesters, tagging each issue so its result is steered back to the issuer.
module pipe_arbiter #(
    parameter int N   = 10,
    parameter int LAT = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [4*N-1:0] req0_ops,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [4*N-1:0] req1_ops,
    output logic [N-1:0]   pipe_a,
    output logic [N-1:0]   pipe_b,
    output logic [N-1:0]   pipe_c,
    output logic [N-1:0]   pipe_d,
    input  logic [N-1:0]   pipe_f,
    output logic           rsp0_valid,
    output logic           rsp1_valid,
    output logic [N-1:0]   rsp_data,
    output logic           busy
);

    // Which requester wins the next tie.
    typedef enum logic {PRIO_REQ0, PRIO_REQ1} prio_e;

    prio_e          prio_q, prio_d;
    logic           gnt0, gnt1, xfer;
    logic [4*N-1:0] ops_sel;
    logic [LAT:0]   tag_valid;
    logic [LAT:0]   tag_id;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves one unassigned and infers a latch.
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        prio_d = prio_q;
        if (rst_n) begin
            if (req0_valid && (!req1_valid || prio_q == PRIO_REQ0)) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
        // The pointer moves only on a real grant, to favour the other side.
        if (gnt0) begin
            prio_d = PRIO_REQ1;
        end else if (gnt1) begin
            prio_d = PRIO_REQ0;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign xfer       = gnt0 | gnt1;
    assign ops_sel    = gnt1 ? req1_ops : req0_ops;

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
        if (!rst_n) begin
            prio_q <= PRIO_REQ0;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_a <= '0;
            pipe_b <= '0;
            pipe_c <= '0;
            pipe_d <= '0;
        end else if (xfer) begin
            {pipe_a, pipe_b, pipe_c, pipe_d} <= ops_sel;
        end
    end

    // Stage k holds the tag of the issue presented to the pipe k cycles ago.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_valid <= '0;
        end else begin
            tag_valid <= {tag_valid[LAT-1:0], xfer};
        end
    end

    // NOTE: the id bits are left unreset; they are only ever read qualified by their valid bit.
    always_ff @(posedge clk) begin
        tag_id <= {tag_id[LAT-1:0], gnt1};
    end

    assign rsp0_valid = tag_valid[LAT] & ~tag_id[LAT];
    assign rsp1_valid = tag_valid[LAT] &  tag_id[LAT];
    assign rsp_data   = pipe_f;
    assign busy       = |tag_valid;

endmodule
